dmux_stream: RTL and testbench
==============================

Name: dmux_stream

Overview:
- Registered 1-to-N demultiplexer with valid/ready handshakes.
- Generalises the 4-way bit dmux in three ways: parametrised output count, a multi-bit payload, and a one-entry output buffer.
- Adds an optional broadcast mode that delivers one word to every output, with independent per-output acceptance.
- Sits between a single producer (CPU/memory-mapped write path) and several consumers (peripheral register banks) in the FPGA top level.

Parameters:
- WIDTH, 16, payload width in bits (Hack word).
- SEL_WIDTH, 2, select width; NUM_OUT = 2**SEL_WIDTH outputs (SEL_WIDTH >= 1).
- BROADCAST_EN, 1, 1 = in_bcast honoured; 0 = in_bcast ignored and broadcast logic removed.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  payload.
- in_sel  input  SEL_WIDTH  destination index.
- in_bcast  input  1  deliver to all outputs (BROADCAST_EN=1 only).
- out_valid  output  NUM_OUT  per-output valid; bit i for output i.
- out_ready  input  NUM_OUT  per-output ready.
- out_data  output  WIDTH  shared payload bus, valid wherever an out_valid bit is set.
- busy  output  1  buffer holds an undelivered word.

Behaviour:
- Reset (rst=1 at clock edge) clears all state:
  - full=0, pend_mask=0, data_q=0.
  - Outputs after reset: out_valid=0, out_data=0, busy=0, in_ready=1.
  - rst has priority over every other event.
- Reset mid-operation: a held or partially delivered word is discarded, with no further out_valid for it.
- State:
  - full (1b)
  - data_q (WIDTH)
  - pend_mask (NUM_OUT): outputs still owed the current word.
- Output handshake:
  - out_valid = pend_mask when full, else 0.
  - out_data = data_q.
  - busy = full.
  - Output i transfers (fire_i) when out_valid[i] & out_ready[i].
- Retire: full & ((pend_mask & ~fire) == 0). The held word leaves the buffer this cycle.
- in_ready = !full | retire. This is a combinational path from out_ready to in_ready and is allowed. No path exists from in_valid to out_valid.
- Input accept: in_valid & in_ready. On accept at clock edge:
  - data_q <= in_data, full <= 1.
  - pend_mask <= all ones if (BROADCAST_EN & in_bcast), else onehot(in_sel).
- Otherwise at clock edge:
  - pend_mask <= pend_mask & ~fire.
  - full <= full & ~retire.
- Accept and retire in the same cycle: the new word replaces the old one with no bubble, sustaining 1 word/cycle.
- Latency: a word accepted at edge k drives out_valid from cycle k+1. Minimum 1 cycle; no maximum (backpressure holds indefinitely).
- Data stability: while full, data_q and set pend_mask bits are stable until they fire. Bits never re-assert for the same word.
- Broadcast:
  - Each output may accept in a different cycle.
  - Outputs that already fired drop out_valid.
  - The word retires only when the last pending output fires.
- Ignored inputs:
  - out_ready bits with out_valid low have no effect.
  - in_sel and in_data are don't-care when in_valid=0.
  - in_bcast is don't-care when BROADCAST_EN=0.
- No combinational loops. All state is in the clk domain.

Test Plan:
1. Reset then idle: assert rst 2 cycles -> out_valid=0000, busy=0, in_ready=1, out_data=0x0000.
2. Single route: in_data=0x1234, in_sel=2, out_ready=1111 -> next cycle out_valid=0100, out_data=0x1234; word retires that cycle, busy=0 the cycle after.
3. Backpressure: word 0xBEEF, sel=1, out_ready=0000 for 5 cycles -> out_valid=0010 held, in_ready=0, data stable. Raise out_ready[1] -> transfer and in_ready=1 in the same cycle.
4. Back-to-back streaming: 8 words 0x0001..0x0008 with sel=0,1,2,3,0,1,2,3, in_valid continuously high, out_ready=1111 -> one word per cycle, correct one-hot out_valid each cycle, order preserved, no bubbles.
5. Broadcast with staggered readies: in_data=0xA5A5, in_bcast=1.
   - out_ready[0] high cycle 1, [3] cycle 2, [1] cycle 3, [2] cycle 4.
   - out_valid goes 1111 -> 1110 -> 0110 -> 0100 -> retire in cycle 4.
   - in_ready=0 for cycles 1-3, 1 in cycle 4.
6. Reset mid-broadcast and BROADCAST_EN=0:
   - rst after 2 of 4 outputs fire -> out_valid=0000 the next cycle; the word never reappears.
   - Separate instance with BROADCAST_EN=0 and in_bcast=1, sel=3 -> out_valid=1000 only.

Source files
------------

// File: rtl/dmux_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmux_stream : registered 1-to-N valid/ready demux with optional broadcast
// Revision    : 1.0
// ----------------------------------------------------------------------------
module dmux_stream #(
   parameter int WIDTH        = 16,
   parameter int SEL_WIDTH    = 2,
   parameter int BROADCAST_EN = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_WIDTH-1:0]      in_sel,
   input  logic                      in_bcast,
   output logic [(2**SEL_WIDTH)-1:0] out_valid,
   input  logic [(2**SEL_WIDTH)-1:0] out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      busy
);

   localparam int NUM_OUT = 2**SEL_WIDTH;
   localparam logic [NUM_OUT-1:0] ONE_LSB = {{(NUM_OUT-1){1'b0}}, 1'b1};

   logic                 full_q, full_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [NUM_OUT-1:0]   pend_mask_q, pend_mask_d;

   logic [NUM_OUT-1:0]   fire;
   logic [NUM_OUT-1:0]   dest_mask;
   logic                 retire;
   logic                 accept;
   logic                 bcast;

   // With broadcast disabled the request is tied off so the all-ones path folds away.
   generate
      if (BROADCAST_EN != 0) begin : g_bcast
         assign bcast = in_bcast;
      end else begin : g_no_bcast
         assign bcast = in_bcast & 1'b0;
      end
   endgenerate

   assign out_valid = full_q ? pend_mask_q : '0;
   assign out_data  = data_q;
   assign busy      = full_q;
   assign fire      = out_valid & out_ready;
   assign retire    = full_q & ((pend_mask_q & ~fire) == '0);
   assign in_ready  = ~full_q | retire;
   assign accept    = in_valid & in_ready;
   assign dest_mask = bcast ? {NUM_OUT{1'b1}} : (ONE_LSB << in_sel);

   always_comb begin
      full_d      = full_q & ~retire;
      data_d      = data_q;
      pend_mask_d = pend_mask_q & ~fire;
      // A new word may overwrite the retiring one in the same cycle, keeping full throughput.
      if (accept) begin
         full_d      = 1'b1;
         data_d      = in_data;
         pend_mask_d = dest_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q      <= 1'b0;
         data_q      <= '0;
         pend_mask_q <= '0;
      end else begin
         full_q      <= full_d;
         data_q      <= data_d;
         pend_mask_q <= pend_mask_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmux_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmux_stream : directed vectors, corner sequences and randomized scoreboard
// ----------------------------------------------------------------------------
module tb_dmux_stream;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_bcast;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] out_data;
   logic        busy;

   logic        nb_in_valid;
   logic        nb_in_ready;
   logic [15:0] nb_in_data;
   logic [1:0]  nb_in_sel;
   logic        nb_in_bcast;
   logic [3:0]  nb_out_valid;
   logic [3:0]  nb_out_ready;
   logic [15:0] nb_out_data;
   logic        nb_busy;

   int checks = 0;
   int errors = 0;

   dmux_stream #(.WIDTH(16), .SEL_WIDTH(2), .BROADCAST_EN(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   dmux_stream #(.WIDTH(16), .SEL_WIDTH(2), .BROADCAST_EN(0)) dut_nb (
      .clk(clk), .rst(rst),
      .in_valid(nb_in_valid), .in_ready(nb_in_ready), .in_data(nb_in_data),
      .in_sel(nb_in_sel), .in_bcast(nb_in_bcast),
      .out_valid(nb_out_valid), .out_ready(nb_out_ready), .out_data(nb_out_data),
      .busy(nb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   typedef struct {
      logic        in_valid;
      logic [15:0] in_data;
      logic [1:0]  in_sel;
      logic        in_bcast;
      logic [3:0]  out_ready;
      logic [3:0]  exp_valid;
      logic [15:0] exp_data;
      logic        exp_ready;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];

   // Per-output scoreboard: words each output is still owed.
   logic [15:0] sb [4][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic iv, input logic [15:0] d, input logic [1:0] s,
                          input logic b, input logic [3:0] ordy, input logic [3:0] ev,
                          input logic [15:0] ed, input logic er, input logic eb);
      vec_t v;
      v.in_valid = iv; v.in_data = d; v.in_sel = s; v.in_bcast = b; v.out_ready = ordy;
      v.exp_valid = ev; v.exp_data = ed; v.exp_ready = er; v.exp_busy = eb;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  oh;
      logic [3:0]  ev;
      logic [3:0]  dest;
      logic        any;
      logic        er;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
      nb_in_valid = 1'b0; nb_in_data = '0; nb_in_sel = '0; nb_in_bcast = 1'b0; nb_out_ready = '0;

      // idle after reset
      add_vec(0, 16'h0000, 0, 0, 4'b0000, 4'b0000, 16'h0000, 1, 0);
      // single route to output 2
      add_vec(1, 16'h1234, 2, 0, 4'b1111, 4'b0000, 16'h0000, 1, 0);
      add_vec(0, 16'h0000, 0, 0, 4'b1111, 4'b0100, 16'h1234, 1, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b1111, 4'b0000, 16'h1234, 1, 0);
      // backpressure: a competing word must not be taken while blocked
      add_vec(1, 16'hBEEF, 1, 0, 4'b0000, 4'b0000, 16'h1234, 1, 0);
      for (int k = 0; k < 5; k++)
         add_vec(1, 16'h5555, 3, 0, 4'b0000, 4'b0010, 16'hBEEF, 0, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b0010, 4'b0010, 16'hBEEF, 1, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b0000, 4'b0000, 16'hBEEF, 1, 0);
      // back-to-back streaming
      for (int k = 0; k < 8; k++) begin
         oh = 4'b0001 << ((k + 3) % 4);
         add_vec(1, 16'(k + 1), 2'(k % 4), 0, 4'b1111,
                 (k == 0) ? 4'b0000 : oh, (k == 0) ? 16'hBEEF : 16'(k), 1, k != 0);
      end
      add_vec(0, 16'h0000, 0, 0, 4'b1111, 4'b1000, 16'h0008, 1, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b1111, 4'b0000, 16'h0008, 1, 0);
      // broadcast with staggered readies (extra ready bits on fired outputs)
      add_vec(1, 16'hA5A5, 0, 1, 4'b0000, 4'b0000, 16'h0008, 1, 0);
      add_vec(0, 16'h0000, 0, 0, 4'b0001, 4'b1111, 16'hA5A5, 0, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b1001, 4'b1110, 16'hA5A5, 0, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b1011, 4'b0110, 16'hA5A5, 0, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b0100, 4'b0100, 16'hA5A5, 1, 1);
      add_vec(0, 16'h0000, 0, 0, 4'b0000, 4'b0000, 16'hA5A5, 1, 0);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         in_valid = vecs[i].in_valid; in_data = vecs[i].in_data; in_sel = vecs[i].in_sel;
         in_bcast = vecs[i].in_bcast; out_ready = vecs[i].out_ready;
         #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
         chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ready));
         chk($sformatf("vec%0d busy", i),      32'(busy),      32'(vecs[i].exp_busy));
         step();
      end

      // reset in the middle of a broadcast, with a word offered during reset
      in_valid = 1'b1; in_data = 16'h7777; in_sel = 0; in_bcast = 1'b1; out_ready = 4'b0000;
      #1; chk("rstb accept ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0001;
      #1; chk("rstb valid0", 32'(out_valid), 32'hF);
      step();
      out_ready = 4'b0010;
      #1; chk("rstb valid1", 32'(out_valid), 32'hE);
      step();
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h9999; in_sel = 0; out_ready = 4'b0000;
      #1; chk("rstb valid2", 32'(out_valid), 32'hC);
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rstb post%0d out_valid", k), 32'(out_valid), 32'h0);
         chk($sformatf("rstb post%0d busy", k), 32'(busy), 32'h0);
         chk($sformatf("rstb post%0d out_data", k), 32'(out_data), 32'h0);
         chk($sformatf("rstb post%0d in_ready", k), 32'(in_ready), 32'h1);
         step();
      end

      // broadcast disabled: in_bcast is ignored, only the selected output is owed
      nb_in_valid = 1'b1; nb_in_data = 16'h3C3C; nb_in_sel = 2'd3; nb_in_bcast = 1'b1;
      nb_out_ready = 4'b0000;
      #1; chk("nb accept ready", 32'(nb_in_ready), 32'd1);
      step();
      nb_in_valid = 1'b0; nb_in_bcast = 1'b0;
      #1;
      chk("nb out_valid", 32'(nb_out_valid), 32'h8);
      chk("nb out_data", 32'(nb_out_data), 32'h3C3C);
      chk("nb busy", 32'(nb_busy), 32'h1);
      nb_out_ready = 4'b1000;
      #1; chk("nb retire ready", 32'(nb_in_ready), 32'd1);
      step();
      #1; chk("nb after retire", 32'(nb_out_valid), 32'h0);

      // randomized traffic against the per-output scoreboard
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 16'($urandom);
         in_sel    = 2'($urandom_range(0, 3));
         in_bcast  = ($urandom_range(0, 3) == 0);
         out_ready = 4'($urandom);
         #1;
         ev = '0;
         any = 1'b0;
         for (int i = 0; i < 4; i++) begin
            ev[i] = (sb[i].size() != 0);
            any   = any | ev[i];
         end
         chk($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(ev));
         chk($sformatf("rnd%0d busy", cyc), 32'(busy), 32'(any));
         for (int i = 0; i < 4; i++) begin
            if (ev[i] && out_ready[i]) begin
               chk($sformatf("rnd%0d data out%0d", cyc, i), 32'(out_data), 32'(sb[i][0]));
               void'(sb[i].pop_front());
            end
         end
         er = 1'b1;
         for (int i = 0; i < 4; i++)
            if (sb[i].size() != 0) er = 1'b0;
         chk($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(er));
         if (in_valid && er) begin
            dest = in_bcast ? 4'b1111 : (4'b0001 << in_sel);
            for (int i = 0; i < 4; i++)
               if (dest[i]) sb[i].push_back(in_data);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
